// File: rtl/escaner_vehiculos_pkg.sv
// Shared definitions for the vehicle matrix scanner: FSM encoding, bus and
// matrix geometry, frog coordinate widths and prescaler counter width.
package escaner_vehiculos_pkg;

   localparam int unsigned DATAWIDTH_BUS = 8;
   localparam int unsigned MATRIX_ROWS   = 8;
   localparam int unsigned VEH_ROWS      = 6;
   localparam int unsigned FROG_ROW_W    = 3;
   localparam int unsigned FROG_COL_W    = 3;
   localparam int unsigned DIV_W         = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DONE  = 2'd3
   } esv_state_t;

endpackage

// File: rtl/escaner_vehiculos_if.sv
// Scanner bus: vehicle rows, frog position and frame control in, matrix drive
// and status out.
//   master : vehicle level / test side (drives *_IN, reads *_OUT)
//   slave  : escaner_vehiculos
interface escaner_vehiculos_if #(
   parameter int unsigned DATAWIDTH_BUS = escaner_vehiculos_pkg::DATAWIDTH_BUS
) ();
   import escaner_vehiculos_pkg::*;

   logic [DATAWIDTH_BUS-1:0] ESV_REG_0_IN;
   logic [DATAWIDTH_BUS-1:0] ESV_REG_1_IN;
   logic [DATAWIDTH_BUS-1:0] ESV_REG_2_IN;
   logic [DATAWIDTH_BUS-1:0] ESV_REG_3_IN;
   logic [DATAWIDTH_BUS-1:0] ESV_REG_4_IN;
   logic [DATAWIDTH_BUS-1:0] ESV_REG_5_IN;
   logic [FROG_ROW_W-1:0]    ESV_FROG_ROW_IN;
   logic [FROG_COL_W-1:0]    ESV_FROG_COL_IN;
   logic                     ESV_START_IN;
   logic                     ESV_CLR_IN;
   logic [MATRIX_ROWS-1:0]   ESV_ROW_OUT;
   logic [DATAWIDTH_BUS-1:0] ESV_COL_OUT;
   logic                     ESV_BUSY_OUT;
   logic                     ESV_DONE_OUT;
   logic                     ESV_COLISION_OUT;

   modport master (
      output ESV_REG_0_IN, ESV_REG_1_IN, ESV_REG_2_IN, ESV_REG_3_IN,
             ESV_REG_4_IN, ESV_REG_5_IN, ESV_FROG_ROW_IN, ESV_FROG_COL_IN,
             ESV_START_IN, ESV_CLR_IN,
      input  ESV_ROW_OUT, ESV_COL_OUT, ESV_BUSY_OUT, ESV_DONE_OUT,
             ESV_COLISION_OUT
   );

   modport slave (
      input  ESV_REG_0_IN, ESV_REG_1_IN, ESV_REG_2_IN, ESV_REG_3_IN,
             ESV_REG_4_IN, ESV_REG_5_IN, ESV_FROG_ROW_IN, ESV_FROG_COL_IN,
             ESV_START_IN, ESV_CLR_IN,
      output ESV_ROW_OUT, ESV_COL_OUT, ESV_BUSY_OUT, ESV_DONE_OUT,
             ESV_COLISION_OUT
   );

endinterface

// File: rtl/escaner_vehiculos_divisor.sv
// ESV_DIVISOR: row-hold prescaler. Counts 0..DIV_SCAN-1 while enabled.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over enable)
//   en         : count enable
//   first_c    : counter is at 0 (first cycle of the current row)
//   tick_c     : one-cycle row-advance pulse on the last count
module escaner_vehiculos_divisor #(
   parameter int unsigned DIV_SCAN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic first_c,
   output logic tick_c
);
   import escaner_vehiculos_pkg::*;

   logic [DIV_W-1:0] cnt;

   assign first_c = (cnt == '0);
   assign tick_c  = en && (cnt == DIV_W'(DIV_SCAN - 1));

   // Wrap to 0 on the tick so DIV_SCAN=1 ticks every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt <= '0;
      else if (clr)     cnt <= '0;
      else if (en)      cnt <= tick_c ? '0 : cnt + DIV_W'(1);
   end

endmodule

// File: rtl/escaner_vehiculos.sv
// Vehicle matrix scanner: snapshots six vehicle rows plus the frog position
// on request, then drives an 8-row multiplexed display one row at a time
// (DIV_SCAN cycles per row) and flags frog/vehicle overlap.
//   ESV_CLOCK : system clock
//   ESV_RESET : async active-low reset
//   esv       : scanner bus (slave side); all outputs registered
module escaner_vehiculos #(
   parameter int unsigned DATAWIDTH_BUS = escaner_vehiculos_pkg::DATAWIDTH_BUS,
   parameter int unsigned DIV_SCAN      = 4
) (
   input  logic               ESV_CLOCK,
   input  logic               ESV_RESET,
   escaner_vehiculos_if.slave esv
);
   import escaner_vehiculos_pkg::*;

   localparam int unsigned DW = DATAWIDTH_BUS;

   esv_state_t            state;
   logic [FROG_ROW_W-1:0] row_cnt;
   logic [FROG_ROW_W-1:0] frog_row_q;
   logic [FROG_COL_W-1:0] frog_col_q;
   logic [DW-1:0]         veh_q [VEH_ROWS];

   logic [DW-1:0]         veh_row_c;
   logic [DW-1:0]         frog_mask_c;
   logic [DW-1:0]         col_c;
   logic                  on_frog_row_c;
   logic                  hit_c;
   logic                  first_c;
   logic                  tick_c;

   escaner_vehiculos_divisor #(.DIV_SCAN(DIV_SCAN)) u_divisor (
      .clk     (ESV_CLOCK),
      .rst_n   (ESV_RESET),
      .clr     (state != ST_SCAN),
      .en      (state == ST_SCAN),
      .first_c (first_c),
      .tick_c  (tick_c)
   );

   // Matrix rows 0 and 7 are empty border rows; rows 1..6 map to snapshots 0..5
   always_comb begin
      veh_row_c = '0;
      for (int k = 1; k <= int'(VEH_ROWS); k++) begin
         if (int'(row_cnt) == k) veh_row_c = veh_q[k-1];
      end
   end

   assign frog_mask_c   = DW'(1) << frog_col_q;
   assign on_frog_row_c = (row_cnt == frog_row_q);
   assign col_c         = veh_row_c | (on_frog_row_c ? frog_mask_c : '0);
   // Evaluated once per frame: first cycle the frog row is being scanned
   assign hit_c         = (state == ST_SCAN) && first_c && on_frog_row_c &&
                          (|(veh_row_c & frog_mask_c));

   // FSM, snapshot, row counter and registered outputs
   always_ff @(posedge ESV_CLOCK or negedge ESV_RESET) begin
      if (!ESV_RESET) begin
         state                <= ST_IDLE;
         row_cnt              <= '0;
         frog_row_q           <= '0;
         frog_col_q           <= '0;
         for (int i = 0; i < int'(VEH_ROWS); i++) veh_q[i] <= '0;
         esv.ESV_ROW_OUT      <= '0;
         esv.ESV_COL_OUT      <= '0;
         esv.ESV_BUSY_OUT     <= 1'b0;
         esv.ESV_DONE_OUT     <= 1'b0;
         esv.ESV_COLISION_OUT <= 1'b0;
      end else begin
         esv.ESV_ROW_OUT  <= '0;
         esv.ESV_COL_OUT  <= '0;
         esv.ESV_BUSY_OUT <= (state != ST_IDLE);
         esv.ESV_DONE_OUT <= (state == ST_DONE);

         // Set has priority over clear
         if (hit_c)               esv.ESV_COLISION_OUT <= 1'b1;
         else if (esv.ESV_CLR_IN) esv.ESV_COLISION_OUT <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               if (esv.ESV_START_IN) state <= ST_LATCH;
            end
            ST_LATCH: begin
               veh_q[0]   <= esv.ESV_REG_0_IN;
               veh_q[1]   <= esv.ESV_REG_1_IN;
               veh_q[2]   <= esv.ESV_REG_2_IN;
               veh_q[3]   <= esv.ESV_REG_3_IN;
               veh_q[4]   <= esv.ESV_REG_4_IN;
               veh_q[5]   <= esv.ESV_REG_5_IN;
               frog_row_q <= esv.ESV_FROG_ROW_IN;
               frog_col_q <= esv.ESV_FROG_COL_IN;
               row_cnt    <= '0;
               state      <= ST_SCAN;
            end
            ST_SCAN: begin
               esv.ESV_ROW_OUT <= MATRIX_ROWS'(1) << row_cnt;
               esv.ESV_COL_OUT <= col_c;
               if (tick_c) begin
                  if (row_cnt == FROG_ROW_W'(MATRIX_ROWS - 1)) state <= ST_DONE;
                  else row_cnt <= row_cnt + FROG_ROW_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/escaner_vehiculos.md
ESCANER_VEHICULOS -- requirements
Module: escaner_vehiculos

Interface
REQ-001 SHALL have parameter DATAWIDTH_BUS, default 8, width of each vehicle row and of the column bus.
REQ-002 SHALL have parameter DIV_SCAN, default 4, clock cycles each matrix row is held; legal range 1..255.
REQ-003 SHALL have one clock, ESV_CLOCK; the reset, ESV_RESET, SHALL be asynchronous and active-low.
REQ-004 ESV_CLOCK  in  1  system clock, all state on rising edge.
REQ-005 ESV_RESET  in  1  asynchronous active-low reset.
REQ-006 ESV_REG_0_IN .. ESV_REG_5_IN  in  8 each  vehicle row contents from the vehicle level block, bit n = column n occupied.
REQ-007 ESV_FROG_ROW_IN  in  3  frog matrix row, 0..7.
REQ-008 ESV_FROG_COL_IN  in  3  frog matrix column, 0..7.
REQ-009 ESV_START_IN  in  1  frame request, level-sampled.
REQ-010 ESV_CLR_IN  in  1  clears sticky collision flag.
REQ-011 ESV_ROW_OUT  out  8  one-hot active-high matrix row select.
REQ-012 ESV_COL_OUT  out  8  active-high column data for selected row.
REQ-013 ESV_BUSY_OUT  out  1  high while a frame is in progress.
REQ-014 ESV_DONE_OUT  out  1  one-cycle pulse at frame end.
REQ-015 ESV_COLISION_OUT  out  1  sticky frog/vehicle overlap flag.

Function
REQ-016 FSM states SHALL be IDLE, LATCH, SCAN, DONE.
REQ-017 IDLE -> LATCH when ESV_START_IN=1; otherwise stay.
REQ-018 LATCH (1 cycle): capture all six rows and frog row/col into snapshot registers; -> SCAN with row counter=0, divider=0.
REQ-019 SCAN: divider counts 0..DIV_SCAN-1; at DIV_SCAN-1 divider wraps to 0 and row counter increments; at row 7 and divider DIV_SCAN-1 -> DONE.
REQ-020 DONE (1 cycle): ESV_DONE_OUT=1; -> IDLE.
REQ-021 ESV_START_IN in LATCH, SCAN or DONE SHALL be ignored; no queuing.
REQ-022 Row mapping: matrix row 0 and row 7 carry no vehicles; matrix row k (1..6) carries snapshot ESV_REG_(k-1).
REQ-023 In SCAN, ESV_ROW_OUT = 1 << row counter; ESV_COL_OUT = vehicle bits of that row OR (1 << frog col) when row counter = frog row.
REQ-024 In IDLE, LATCH, DONE, ESV_ROW_OUT and ESV_COL_OUT SHALL be 0.
REQ-025 ESV_ROW_OUT/ESV_COL_OUT SHALL be registered; they reflect the state one cycle after the counter change is decided, with no glitch between rows.
REQ-026 ESV_BUSY_OUT = 1 in LATCH, SCAN, DONE; 0 in IDLE.
REQ-027 Latency: START sampled at edge t -> LATCH during t..t+1, first row driven from t+2, DONE pulse at t+2+8*DIV_SCAN, IDLE at t+3+8*DIV_SCAN.
REQ-028 Collision: in the first SCAN cycle of the frog row, if the snapshot vehicle bit at frog col is 1, ESV_COLISION_OUT SHALL set on the next edge; rows 0 and 7 never collide.
REQ-029 ESV_COLISION_OUT SHALL hold until ESV_CLR_IN=1; simultaneous set and clear: set wins.
REQ-030 Inputs changing during a frame SHALL not affect that frame (snapshot only).

Reset
REQ-031 ESV_RESET low SHALL immediately force IDLE, counters 0, snapshots 0, all outputs 0, including mid-frame; no DONE pulse is issued for an aborted frame.
REQ-032 After release, first START is accepted on the first rising edge.

Structure
REQ-033 Shared package SHALL hold FSM state encoding, DATAWIDTH_BUS, matrix row count 8 and frog row/column widths.
REQ-034 One sub-module is natural: ESV_DIVISOR, the DIV_SCAN prescaler emitting a one-cycle row-advance tick with synchronous clear.

Verification
REQ-035 Reset mid-SCAN (row 3) -> all outputs 0 within same cycle, state IDLE, COLISION 0.
REQ-036 REG_0=8'hC0, frog row 1 col 7, START, DIV_SCAN=4 -> row 1 COL_OUT=8'hC0, COLISION=1 after row 1, DONE at t+34.
REQ-037 REG_2=8'h0F, frog row 3 col 4 -> row 3 COL_OUT=8'h1F, COLISION stays 0.
REQ-038 START held high continuously -> back-to-back frames, each DONE exactly 8*DIV_SCAN+3 cycles apart, START mid-frame ignored.
REQ-039 Inputs changed during SCAN -> displayed rows match values captured in LATCH.
REQ-040 CLR and collision set in same cycle -> COLISION=1; CLR alone next cycle -> COLISION=0.
